// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter.
// Included by sprite_clip and sprite_blitter via import sprite_pkg::*.
package sprite_pkg;

  localparam int SPRITE_DIM    = 16;
  localparam int SPRITE_TEXELS = 256;
  localparam int ROM_AW        = 9;
  localparam int PIX_W         = 4;
  localparam int COORD_W       = 10;
  localparam int IDX_W         = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITE_TEXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

  // Request captured when a start is accepted.
  typedef struct packed {
    logic [ROM_AW-1:0]  base;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               hflip;
  } blit_req_t;

  // Screen column offset of a texel; mirrored inside the sprite when flipped.
  function automatic logic [3:0] texel_col(input logic [3:0] col, input logic hflip);
    return hflip ? (4'(SPRITE_DIM - 1) - col) : col;
  endfunction

endpackage

// File: rtl/sprite_clip.sv
// Per-texel write qualifier: a texel is written only while running, when it is
// not the transparent index and when it lands inside the visible screen area.
module sprite_clip
  import sprite_pkg::*;
#(
  parameter int unsigned      SCREEN_W        = 640,
  parameter int unsigned      SCREEN_H        = 480,
  parameter logic [PIX_W-1:0] TRANSPARENT_IDX = 4'h0
) (
  input  logic               run_i,
  input  logic [PIX_W-1:0]   texel_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic               write_o
);

  // One extra bit so a limit of 1024 (everything visible) is still representable.
  localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H);

  logic opaque;
  logic on_screen;

  // Combine transparency and screen-bounds tests into the write qualifier.
  always_comb begin
    opaque    = (texel_i != TRANSPARENT_IDX);
    on_screen = ({1'b0, x_i} < X_LIM) && ({1'b0, y_i} < Y_LIM);
    write_o   = run_i && opaque && on_screen;
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks the 256 texels of a 16x16 sprite in the ROM (registered,
// one-cycle read) and issues framebuffer writes at (pos_x+col, pos_y+row),
// skipping transparent and off-screen texels, with fb_ready back-pressure.
// Optional feature: define SPRITE_HFLIP_EN to add the hflip input (mirror columns).
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned      SCREEN_W        = 640,
  parameter int unsigned      SCREEN_H        = 480,
  parameter logic [PIX_W-1:0] TRANSPARENT_IDX = 4'h0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [ROM_AW-1:0]  sprite_base,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
`ifdef SPRITE_HFLIP_EN
  input  logic               hflip,
`endif
  output logic               busy,
  output logic               done,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   rom_data,
  output logic               fb_we,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic [PIX_W-1:0]   fb_data,
  input  logic               fb_ready
);

  blit_state_t        state_q, state_d;
  blit_req_t          req_q, req_d;
  logic [IDX_W:0]     cnt_q, cnt_d;     // issue counter: next texel to fetch
  logic [IDX_W-1:0]   pix_q, pix_d;     // texel currently presented by the ROM

  logic               start_hflip;
  logic               running;
  logic               write;
  logic               retire;
  logic [3:0]         col;
  logic [3:0]         row;
  logic [COORD_W-1:0] tex_x;
  logic [COORD_W-1:0] tex_y;

`ifdef SPRITE_HFLIP_EN
  assign start_hflip = hflip;
`else
  assign start_hflip = 1'b0;
`endif

  // Screen coordinates of the presented texel; 10-bit wrap is intentional.
  always_comb begin
    running = (state_q == RUN);
    col     = texel_col(pix_q[3:0], req_q.hflip);
    row     = pix_q[7:4];
    tex_x   = req_q.pos_x + COORD_W'(col);
    tex_y   = req_q.pos_y + COORD_W'(row);
  end

  sprite_clip #(
    .SCREEN_W        (SCREEN_W),
    .SCREEN_H        (SCREEN_H),
    .TRANSPARENT_IDX (TRANSPARENT_IDX)
  ) u_clip (
    .run_i   (running),
    .texel_i (rom_data),
    .x_i     (tex_x),
    .y_i     (tex_y),
    .write_o (write)
  );

  // A texel retires when it needs no write or the framebuffer takes the write.
  assign retire = !write || fb_ready;

  // State register: FSM state, latched request and the two texel counters.
  // NOTE: the request and counters are reset too, not just the state, because
  // fb_x/fb_y are derived from them and must read 0 out of reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
    end
  end

  // Next-state logic: accept start, prime the ROM pipeline, walk the texels.
  always_comb begin
    // NOTE: hold-by-default assignments up front keep this block latch-free.
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          req_d   = '{base: sprite_base, pos_x: pos_x, pos_y: pos_y, hflip: start_hflip};
          cnt_d   = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        pix_d   = cnt_q[IDX_W-1:0];
        cnt_d   = cnt_q + (IDX_W+1)'(1);
        state_d = RUN;
      end
      RUN: begin
        if (retire) begin
          pix_d = cnt_q[IDX_W-1:0];
          cnt_d = cnt_q + (IDX_W+1)'(1);
          if (pix_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: status, ROM address and the framebuffer write port.
  always_comb begin
    busy     = (state_q == PRIME) || (state_q == RUN);
    done     = (state_q == DONE);
    fb_we    = write;
    fb_x     = tex_x;
    fb_y     = tex_y;
    fb_data  = running ? rom_data : '0;
    rom_addr = '0;
    case (state_q)
      PRIME: rom_addr = req_q.base + ROM_AW'(cnt_q[IDX_W-1:0]);
      RUN: begin
        // On a stall the stalled texel's address is re-issued, so the
        // registered ROM keeps presenting it on the next cycle.
        if (retire) rom_addr = req_q.base + ROM_AW'(cnt_q[IDX_W-1:0]);
        else        rom_addr = req_q.base + ROM_AW'(pix_q);
      end
      default: rom_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: table of sprite runs with
// hand-computed write counts, done latency and first/last write positions,
// plus directed reset-state and mid-sprite reset sequences.
module tb_sprite_blitter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [8:0] sprite_base;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
`ifdef SPRITE_HFLIP_EN
  logic       hflip;
`endif
  logic       busy;
  logic       done;
  logic [8:0] rom_addr;
  logic [3:0] rom_data;
  logic       fb_we;
  logic [9:0] fb_x;
  logic [9:0] fb_y;
  logic [3:0] fb_data;
  logic       fb_ready;

  int tests = 0;
  int fails = 0;

  logic [3:0] rom_mem [512];

  always #5 Clk = ~Clk;

  // Registered-read sprite ROM.
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  sprite_blitter dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .sprite_base (sprite_base),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
`ifdef SPRITE_HFLIP_EN
    .hflip       (hflip),
`endif
    .busy        (busy),
    .done        (done),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .fb_we       (fb_we),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_data     (fb_data),
    .fb_ready    (fb_ready)
  );

  typedef struct {
    string name;
    int    base;
    int    px;
    int    py;
    int    pat;        // 0 all 5, 1 checkerboard, 2 row^col, 3 texel0 only
    int    rpat;       // 0 always ready, 1 toggle from texel 5
    bit    hf;
    bit    glitch;     // extra start while busy and in the done cycle
    int    exp_writes;
    int    exp_done;   // posedge count after start at which done is seen
    int    fx;
    int    fy;
    int    lx;
    int    ly;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] tex(input int pat, input int i);
    case (pat)
      0:       return 4'h5;
      1:       return ((((i >> 4) ^ i) & 1) != 0) ? 4'hA : 4'h0;
      2:       return 4'((i & 15) ^ ((i >> 4) & 15));
      default: return (i == 0) ? 4'h3 : 4'h0;
    endcase
  endfunction

  function automatic void coords(input vec_t v, input int i, output int x, output int y);
    int c;
    c = i % 16;
    if (v.hf) c = 15 - c;
    x = (v.px + c) % 1024;
    y = (v.py + i / 16) % 1024;
  endfunction

  function automatic bit vis(input vec_t v, input int i);
    int x, y;
    coords(v, i, x, y);
    return (tex(v.pat, i) != 4'h0) && (x < 640) && (y < 480);
  endfunction

  function automatic int next_vis(input vec_t v, input int from);
    for (int i = from; i < 256; i++) if (vis(v, i)) return i;
    return 256;
  endfunction

  task automatic fill_rom(input int pat, input int base);
    for (int i = 0; i < 512; i++) rom_mem[i] = 4'h0;
    for (int i = 0; i < 256; i++) rom_mem[(base + i) % 512] = tex(pat, i);
  endtask

  task automatic apply_start(input vec_t v);
    @(negedge Clk);
    sprite_base = 9'(v.base);
    pos_x       = 10'(v.px);
    pos_y       = 10'(v.py);
`ifdef SPRITE_HFLIP_EN
    hflip       = v.hf;
`endif
    fb_ready    = 1'b1;
    start       = 1'b1;
    @(negedge Clk);
    start       = 1'b0;
  endtask

  // Run one sprite, comparing every write against the model in order.
  task automatic run_sprite(input vec_t v, output int nw, output int done_edge,
                            output int fx, output int fy, output int lx, output int ly,
                            output int errs);
    int mk, edges, c, ex, ey;
    bit stalled;
    logic [9:0] sx, sy;
    logic [3:0] sd;
    nw = 0; done_edge = -1; errs = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    stalled = 0; sx = '0; sy = '0; sd = '0;
    mk = next_vis(v, 0);
    apply_start(v);
    edges = 1;
    for (int n = 0; n < 1500; n++) begin
      c = edges - 2;
      fb_ready = (v.rpat == 0 || c < 5) ? 1'b1 : 1'(((c - 5) % 2) == 1);
      start = v.glitch && (edges == 20);
      if (start) begin
        pos_x = 10'd300; pos_y = 10'd300; sprite_base = 9'd100;
      end
      #1;
      if (edges == 1) check({v.name, ".busy_prime"}, 32'(busy), 1);
      if (stalled && (!fb_we || fb_x !== sx || fb_y !== sy || fb_data !== sd)) errs++;
      if (fb_we) begin
        if (mk > 255) errs++;
        else begin
          coords(v, mk, ex, ey);
          if (int'(fb_x) != ex || int'(fb_y) != ey || fb_data !== tex(v.pat, mk)) errs++;
        end
        if (fb_ready) begin
          nw++;
          if (fx < 0) begin fx = int'(fb_x); fy = int'(fb_y); end
          lx = int'(fb_x); ly = int'(fb_y);
          mk = next_vis(v, mk + 1);
          stalled = 0;
        end else begin
          stalled = 1; sx = fb_x; sy = fb_y; sd = fb_data;
          if (int'(rom_addr) != (v.base + mk) % 512) errs++;
        end
      end else stalled = 0;
      if (done) begin
        done_edge = edges;
        break;
      end
      @(negedge Clk);
      edges++;
    end
    start = 1'b0;
    if (mk <= 255) errs++;
    if (done_edge >= 0) begin
      // A start coinciding with done must be ignored.
      start    = v.glitch;
      fb_ready = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      #1;
      check({v.name, ".busy_after_done"}, 32'(busy), 0);
      check({v.name, ".done_one_cycle"}, 32'(done), 0);
    end
  endtask

  initial begin
    int nw, de, fx, fy, lx, ly, errs;
    vec_t rv;

    //        name      base  px    py   pat rpat hf    glitch  wr   done fx   fy   lx   ly
    vecs.push_back('{"all5",    0, 100,  50, 0, 0, 1'b0, 1'b0, 256, 258, 100, 50, 115, 65});
    vecs.push_back('{"checker", 0, 100,  50, 1, 0, 1'b0, 1'b0, 128, 258, 101, 50, 114, 65});
    vecs.push_back('{"clip",    0, 632, 472, 0, 0, 1'b0, 1'b0,  64, 258, 632, 472, 639, 479});
    vecs.push_back('{"stall",   0, 100,  50, 0, 1, 1'b0, 1'b0, 256, 509, 100, 50, 115, 65});
    vecs.push_back('{"wrap",  500, 1020, 10, 2, 0, 1'b0, 1'b0, 180, 258,   0, 10,  10, 25});
    vecs.push_back('{"ignore",  0, 100,  50, 0, 0, 1'b0, 1'b1, 256, 258, 100, 50, 115, 65});
`ifdef SPRITE_HFLIP_EN
    vecs.push_back('{"hflip",   0, 200, 100, 3, 0, 1'b1, 1'b0,   1, 258, 215, 100, 215, 100});
`endif

    // Reset state.
    Reset = 1'b1; start = 1'b0; sprite_base = '0; pos_x = '0; pos_y = '0; fb_ready = 1'b0;
`ifdef SPRITE_HFLIP_EN
    hflip = 1'b0;
`endif
    fill_rom(0, 0);
    repeat (3) @(negedge Clk);
    #1;
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.fb_we", 32'(fb_we), 0);
    check("rst.rom_addr", 32'(rom_addr), 0);
    check("rst.fb_x", 32'(fb_x), 0);
    check("rst.fb_y", 32'(fb_y), 0);
    check("rst.fb_data", 32'(fb_data), 0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (vecs[k]) begin
      fill_rom(vecs[k].pat, vecs[k].base);
      run_sprite(vecs[k], nw, de, fx, fy, lx, ly, errs);
      check({vecs[k].name, ".writes"}, 32'(nw), 32'(vecs[k].exp_writes));
      check({vecs[k].name, ".done_edge"}, 32'(de), 32'(vecs[k].exp_done));
      check({vecs[k].name, ".first_x"}, 32'(fx), 32'(vecs[k].fx));
      check({vecs[k].name, ".first_y"}, 32'(fy), 32'(vecs[k].fy));
      check({vecs[k].name, ".last_x"}, 32'(lx), 32'(vecs[k].lx));
      check({vecs[k].name, ".last_y"}, 32'(ly), 32'(vecs[k].ly));
      check({vecs[k].name, ".order_errs"}, 32'(errs), 0);
    end

    // Reset while texel 100 is being presented aborts the sprite.
    rv = vecs[0];
    fill_rom(0, 0);
    apply_start(rv);
    repeat (101) @(negedge Clk);   // now after posedge 102: texel 100 presented
    #1;
    check("midrst.pre_we", 32'(fb_we), 1);
    check("midrst.pre_x", 32'(fb_x), 104);
    check("midrst.pre_y", 32'(fb_y), 56);
    Reset = 1'b1;
    #1;
    check("midrst.fb_we", 32'(fb_we), 0);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.rom_addr", 32'(rom_addr), 0);
    @(negedge Clk);
    #1;
    check("midrst.still_idle_we", 32'(fb_we), 0);
    Reset = 1'b0;
    run_sprite(rv, nw, de, fx, fy, lx, ly, errs);
    check("midrst.redraw_writes", 32'(nw), 256);
    check("midrst.redraw_done", 32'(de), 258);
    check("midrst.redraw_errs", 32'(errs), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
